// File: rtl/flappy_pkg.sv
// flappy_pkg
// Shared definitions for the flappy game datapath blocks.
//   - game_state encodings produced by game_FSM
//   - common bus widths (game state, score, pipe gap)
//   - scheduler FSM state type
//   - sat_step(): saturating "base - n*step, floored" helper used for the
//     period and gap tables
// No ports; this file only holds types, constants and a helper function.
package flappy_pkg;

    localparam int GAME_STATE_W = 4;
    localparam int SCORE_W      = 32;
    localparam int GAP_W        = 10;

    localparam logic [GAME_STATE_W-1:0] GS_IDLE  = 4'd0;
    localparam logic [GAME_STATE_W-1:0] GS_PLAY  = 4'd1;
    localparam logic [GAME_STATE_W-1:0] GS_PAUSE = 4'd2;
    localparam logic [GAME_STATE_W-1:0] GS_DEAD  = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_OVER = 2'd3
    } sched_state_t;

    // Returns max(base - n*step, floor_val) without ever forming a negative
    // intermediate: the reduction is compared against base before it is
    // subtracted, so large n simply lands on the floor.
    function automatic logic [31:0] sat_step(
        input logic [31:0] base,
        input logic [31:0] step,
        input logic [31:0] n,
        input logic [31:0] floor_val
    );
        logic [31:0] reduction;
        reduction = step * n;
        if ((reduction < base) && ((base - reduction) > floor_val)) begin
            return base - reduction;
        end
        return floor_val;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider
// Programmable period counter that produces the scroll wrap strobe.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous reset, active-low
//   run     in   count this cycle (wrap may fire)
//   clear   in   force the count back to zero (highest priority)
//   period  in   cycles per wrap; the counter wraps at period-1
//   wrap    out  combinational strobe, high in the cycle the count sits at
//                period-1 while running (the caller registers it)
// With neither run nor clear asserted the count holds, which is how a pause
// freezes the divider mid-period without losing or adding a tick.
module tick_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        clear,
    input  logic [31:0] period,
    output logic        wrap
);

    logic [31:0] cnt_q;
    logic [31:0] last_count;

    // A zero period is treated like a period of one so the terminal count
    // never underflows; >= keeps the counter safe if period shrinks below
    // the current count.
    assign last_count = (period == 32'd0) ? 32'd0 : (period - 32'd1);
    assign wrap       = run && (cnt_q >= last_count);

    // Count register: clear wins, then wrap back to zero, then increment.
    // When neither run nor clear is asserted the count is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 32'd0;
        end else if (clear) begin
            cnt_q <= 32'd0;
        end else if (wrap) begin
            cnt_q <= 32'd0;
        end else if (run) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/difficulty_scheduler.sv
// difficulty_scheduler
// Paces pipe/floor scrolling with a programmable scroll tick and raises the
// difficulty level as the score grows (shorter tick period, narrower gap).
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-low
//   game_state   in   [3:0] 0 IDLE, 1 PLAY, 2 PAUSE, 3 DEAD, others = IDLE
//   score_count  in   [31:0] current unsigned score
//   scroll_tick  out  one-cycle enable pulse per period
//   pipe_gap     out  [9:0] active pipe gap in pixels
//   level        out  [2:0] active difficulty level
//   level_up     out  one-cycle pulse, coincident with scroll_tick, when a
//                     new level takes effect
// Build option: define DIFFICULTY_IDLE_SCROLL_EN to keep the floor scrolling
// at BASE_PERIOD while idle (title screen); level stays 0 in that mode.
module difficulty_scheduler
    import flappy_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 200000,
    parameter int unsigned PERIOD_STEP = 10000,
    parameter int unsigned MIN_PERIOD  = 100000,
    parameter int unsigned BASE_GAP    = 90,
    parameter int unsigned GAP_STEP    = 5,
    parameter int unsigned MIN_GAP     = 60,
    parameter int unsigned LEVEL_SCORE = 5,
    parameter int unsigned MAX_LEVEL   = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [GAME_STATE_W-1:0] game_state,
    input  logic [SCORE_W-1:0]      score_count,
    output logic                    scroll_tick,
    output logic [GAP_W-1:0]        pipe_gap,
    output logic [2:0]              level,
    output logic                    level_up
);

    sched_state_t state_q, state_d;

    logic        is_play, is_pause, is_dead, is_idle;
    logic        div_run, div_clear, div_hold, div_wrap;
    logic [31:0] div_period;
    logic [31:0] period_q;
    logic [2:0]  level_q;
    logic [GAP_W-1:0] gap_q;
    logic        pending_q;
    logic [31:0] next_level;
    logic [31:0] threshold;
    logic        level_req;
    logic        level_apply;

    assign is_play  = (game_state == GS_PLAY);
    assign is_pause = (game_state == GS_PAUSE);
    assign is_dead  = (game_state == GS_DEAD);
    assign is_idle  = !(is_play || is_pause || is_dead);

    // Threshold for the next level; level+1 is at most 8 so the product of a
    // 32-bit LEVEL_SCORE stays well inside 32 bits for sane settings.
    assign next_level = {29'd0, level_q} + 32'd1;
    assign threshold  = next_level * LEVEL_SCORE;
    assign level_req  = ({29'd0, level_q} < MAX_LEVEL) && (score_count >= threshold);

    // Only a wrap taken while staying in S_RUN may step the level; a wrap in
    // the cycle the game state changes never happens because div_run drops.
    assign level_apply = div_wrap && pending_q && (state_q == S_RUN);

    assign level    = level_q;
    assign pipe_gap = gap_q;

    tick_divider u_tick_divider (
        .clk    (clk),
        .rst    (rst),
        .run    (div_run),
        .clear  (div_clear),
        .period (div_period),
        .wrap   (div_wrap)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic following the game FSM. Unknown encodings already
    // collapse into is_idle, so S_OVER only leaves on an idle request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (is_play) state_d = S_RUN;
            end
            S_RUN: begin
                if (is_pause)     state_d = S_HOLD;
                else if (is_dead) state_d = S_OVER;
                else if (is_idle) state_d = S_IDLE;
            end
            S_HOLD: begin
                if (is_play)      state_d = S_RUN;
                else if (is_dead) state_d = S_OVER;
                else if (is_idle) state_d = S_IDLE;
            end
            S_OVER: begin
                if (is_idle) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Divider control. The counter only runs when the FSM stays in S_RUN, so
    // a state change in the same cycle as a wrap suppresses the tick. Moving
    // into or out of a pause holds the count; every other case clears it.
    always_comb begin
        div_run    = 1'b0;
        div_clear  = 1'b0;
        div_period = period_q;
        div_hold   = (state_d == S_HOLD) || ((state_q == S_HOLD) && (state_d == S_RUN));
        if ((state_q == S_RUN) && (state_d == S_RUN)) begin
            div_run = 1'b1;
        end else if (!div_hold) begin
            div_clear = 1'b1;
        end
`ifdef DIFFICULTY_IDLE_SCROLL_EN
        if ((state_q == S_IDLE) && (state_d == S_IDLE)) begin
            div_run    = 1'b1;
            div_clear  = 1'b0;
            div_period = BASE_PERIOD;
        end
`endif
    end

    // Difficulty registers and output pulses. Returning to idle restores the
    // starting difficulty; a level step is taken only on a wrap with a
    // pending request, and the apply cycle clears pending so a large score
    // jump advances one level per tick. S_OVER simply keeps everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scroll_tick <= 1'b0;
            level_up    <= 1'b0;
            level_q     <= 3'd0;
            gap_q       <= GAP_W'(BASE_GAP);
            period_q    <= BASE_PERIOD;
            pending_q   <= 1'b0;
        end else begin
            scroll_tick <= div_wrap;
            level_up    <= level_apply;
            if (state_d == S_IDLE) begin
                level_q   <= 3'd0;
                gap_q     <= GAP_W'(BASE_GAP);
                period_q  <= BASE_PERIOD;
                pending_q <= 1'b0;
            end else if (level_apply) begin
                level_q   <= level_q + 3'd1;
                period_q  <= sat_step(BASE_PERIOD, PERIOD_STEP, next_level, MIN_PERIOD);
                gap_q     <= GAP_W'(sat_step(BASE_GAP, GAP_STEP, next_level, MIN_GAP));
                pending_q <= 1'b0;
            end else if (((state_q == S_RUN) || (state_q == S_HOLD)) && level_req) begin
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/difficulty_scheduler.md
Name: difficulty_scheduler

Overview:
- Paces pipe/floor scrolling with a programmable-period scroll tick enable, replacing the fixed 250 Hz divider.
- Raises difficulty level as score_count grows, shortening the tick period and narrowing the pipe gap.
- Sits between game_FSM/pipes (inputs) and pipes/collision_detection/image_rendering (consume scroll_tick, pipe_gap).

Parameters:
- BASE_PERIOD, 200000: clk cycles per scroll tick at level 0.
- PERIOD_STEP, 10000: period reduction per level.
- MIN_PERIOD, 100000: period floor; saturate, never go below.
- BASE_GAP, 90: pipe gap in pixels at level 0.
- GAP_STEP, 5: gap reduction per level.
- MIN_GAP, 60: gap floor; saturate.
- LEVEL_SCORE, 5: score points per level.
- MAX_LEVEL, 7: level ceiling; must be < 8.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- game_state  in  4  encoding: 0 IDLE, 1 PLAY, 2 PAUSE, 3 DEAD; any other value is treated as IDLE.
- score_count  in  32  current score, unsigned, from pipes.
- scroll_tick  out  1  single-cycle enable pulse, once per period.
- pipe_gap  out  10  active gap in pixels.
- level  out  3  active difficulty level.
- level_up  out  1  single-cycle pulse when a new level is applied.

Behaviour:
- Reset (rst=0, async): scroll_tick=0, level_up=0, level=0, pipe_gap=BASE_GAP, period=BASE_PERIOD, cnt=0, pending=0, FSM=S_IDLE.
- FSM states: S_IDLE, S_RUN, S_HOLD, S_OVER.
  - S_IDLE→S_RUN on game_state=PLAY.
  - S_RUN→S_HOLD on PAUSE; S_RUN→S_OVER on DEAD; S_RUN→S_IDLE on IDLE.
  - S_HOLD→S_RUN on PLAY; S_HOLD→S_OVER on DEAD; S_HOLD→S_IDLE on IDLE.
  - S_OVER→S_IDLE on IDLE only.
- Entering S_IDLE (from any state) restores the reset values for level, pipe_gap, period, cnt and pending. S_OVER keeps level and pipe_gap frozen so they can be displayed.
- Divider, 32-bit cnt:
  - S_RUN: cnt increments each cycle. When cnt = period-1, cnt←0 and scroll_tick=1 for one cycle (registered output, asserted in the cycle after the compare).
  - First tick after entry from S_IDLE occurs exactly period cycles later.
  - S_HOLD: cnt holds its value and scroll_tick=0. Resume continues from the held count with no extra or lost tick.
  - S_IDLE/S_OVER: cnt=0, no ticks.
- Level request:
  - In S_RUN/S_HOLD, pending←1 when level < MAX_LEVEL and score_count ≥ (level+1)*LEVEL_SCORE. Compute in 32-bit with no overflow.
  - At most one level step per application, even if score jumps several thresholds; remaining steps apply at later ticks.
- Level application:
  - Occurs only on a tick wrap (cnt = period-1) with pending=1.
  - Effects: level←level+1; period←max(BASE_PERIOD-(level+1)*PERIOD_STEP, MIN_PERIOD); pipe_gap←max(BASE_GAP-(level+1)*GAP_STEP, MIN_GAP); pending←0; level_up pulses in the same cycle as the scroll_tick pulse.
  - The subtraction must not underflow: compare before subtracting.
- Simultaneous events:
  - game_state change and wrap in the same cycle: the state transition wins; no tick and no level application.
  - Reset asserted mid-period: immediate async clear, no partial pulse.
- At MAX_LEVEL, pending is never set; outputs stay constant.

Optional Feature:
- Macro: DIFFICULTY_IDLE_SCROLL_EN.
- Defined: in S_IDLE the divider runs at BASE_PERIOD and scroll_tick pulses so the title-screen floor scrolls. level stays 0 and level_up stays 0. Entering S_RUN clears cnt.
- Undefined: no ticks in S_IDLE, as specified above.

Decomposition:
- Shared package flappy_pkg: game_state encodings (GS_IDLE=0, GS_PLAY=1, GS_PAUSE=2, GS_DEAD=3), GAME_STATE_W=4, SCORE_W=32, GAP_W=10.
- One sub-module, tick_divider: programmable period counter with run/hold/clear inputs, period input, and wrap pulse output. Level logic and the FSM stay in difficulty_scheduler.

Test Plan:
Bench parameters: BASE_PERIOD=10, PERIOD_STEP=2, MIN_PERIOD=6, BASE_GAP=90, GAP_STEP=5, MIN_GAP=80, LEVEL_SCORE=5, MAX_LEVEL=7.
- Reset then PLAY, score=0 → first scroll_tick 10 cycles after PLAY, then every 10 cycles; pipe_gap=90, level=0.
- PLAY, score set to 5 mid-period → no change until the next wrap; at the wrap, level=1, level_up and scroll_tick in the same cycle, next interval 8, pipe_gap=85.
- Score jumps 0→23 → levels step 1, 2, 3, 4 on four consecutive wraps; intervals 8, 6, 6, 6; pipe_gap 85, 80, 80, 80 (saturated).
- PLAY 4 cycles into a period, then PAUSE for 50 cycles, then PLAY → no ticks during pause; next tick 6 cycles after resume.
- DEAD at level 2 → ticks stop, level=2 and pipe_gap=80 held; IDLE → level=0, pipe_gap=90. With DIFFICULTY_IDLE_SCROLL_EN defined, IDLE ticks every 10 cycles.
- rst low 3 cycles into a period at level 3 → all outputs return to reset values asynchronously; after release with PLAY, first tick 10 cycles later.
